// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: sends a programmed bit pattern MSB-first, one bit per clk,
// optionally repeating it with idle gaps in between. It also counts "11" pairs
// in the emitted stream, as a reference for a downstream sequence detector.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start_i                       job request, accepted only in IDLE
//   abort_i                       cancel the stream (acts in SHIFT/GAP only)
//   pattern_i, len_i, reps_i      job descriptor, sampled only when start is accepted
//   w_o, w_valid_o                serial bit and its qualifier
//   busy_o, done_o                busy in SHIFT/GAP; done is a one-cycle completion pulse
//   pair_cnt_o                    count of emitted 1s that follow an emitted 1
// All outputs are registered. Outputs change one cycle after start is accepted.
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [REP_W-1:0]   reps_i,
  output logic               w_o,
  output logic               w_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [7:0]         pair_cnt_o
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;      // pattern, left-aligned so bit 0 of the job is the MSB
  logic [MAX_LEN-1:0] sh_q, sh_d;        // remaining bits of the current repetition
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   left_q, left_d;    // bits still to send after the one now on w
  logic [REP_W-1:0]   reps_q, reps_d;    // repetitions left, including the current one
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               hist_q, hist_d;    // the previously emitted bit in this stream was 1
  logic               w_q, w_d;
  logic               wv_q, wv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         pair_q, pair_d;

  logic [LEN_W-1:0]   len_c;
  logic [MAX_LEN-1:0] aligned;
  logic               emit_en, emit_bit, hist_base;
  logic [7:0]         pair_base;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sh_d      = sh_q;
    len_d     = len_q;
    left_d    = left_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    hist_d    = hist_q;
    w_d       = 1'b0;
    wv_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    pair_d    = pair_q;
    emit_en   = 1'b0;
    emit_bit  = 1'b0;
    hist_base = hist_q;
    pair_base = pair_q;

    len_c   = (len_i > MAX_LEN_L) ? MAX_LEN_L : len_i;
    aligned = pattern_i << (MAX_LEN_L - len_c);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          pat_d     = aligned;
          len_d     = len_c;
          reps_d    = (reps_i == '0) ? REP_W'(1) : reps_i;
          pair_base = 8'd0;
          hist_base = 1'b0;
          pair_d    = 8'd0;
          hist_d    = 1'b0;
          if (len_c != '0) begin
            state_d  = SHIFT;
            emit_en  = 1'b1;
            emit_bit = aligned[MAX_LEN-1];
            sh_d     = aligned << 1;
            left_d   = len_c - LEN_W'(1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (left_q != '0) begin
          emit_en  = 1'b1;
          emit_bit = sh_q[MAX_LEN-1];
          sh_d     = sh_q << 1;
          left_d   = left_q - LEN_W'(1);
        end else if (reps_q > REP_W'(1)) begin
          reps_d = reps_q - REP_W'(1);
          if (GAP_CYC == 0) begin
            // Back-to-back repetitions: the bit history carries across.
            emit_en  = 1'b1;
            emit_bit = pat_q[MAX_LEN-1];
            sh_d     = pat_q << 1;
            left_d   = len_q - LEN_W'(1);
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYC - 1);
            busy_d  = 1'b1;
            hist_d  = 1'b0;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        hist_d = 1'b0;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          state_d  = SHIFT;
          emit_en  = 1'b1;
          emit_bit = pat_q[MAX_LEN-1];
          sh_d     = pat_q << 1;
          left_d   = len_q - LEN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit_en) begin
      w_d    = emit_bit;
      wv_d   = 1'b1;
      busy_d = 1'b1;
      hist_d = emit_bit;
      pair_d = (emit_bit && hist_base && (pair_base != 8'hFF)) ? pair_base + 8'd1 : pair_base;
    end

    // Abort overrides stepping; the pair count keeps the value it has reached.
    if (abort_i && ((state_q == SHIFT) || (state_q == GAP))) begin
      state_d = IDLE;
      w_d     = 1'b0;
      wv_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pair_d  = pair_q;
      hist_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      left_q  <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      hist_q  <= 1'b0;
      w_q     <= 1'b0;
      wv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pair_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      left_q  <= left_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      hist_q  <= hist_d;
      w_q     <= w_d;
      wv_q    <= wv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pair_q  <= pair_d;
    end
  end

  assign w_o        = w_q;
  assign w_valid_o  = wv_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pair_cnt_o = pair_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst, start_i, abort_i;
  logic [15:0] pattern_i;
  logic [4:0]  len_i;
  logic [3:0]  reps_i;
  logic        w_o, w_valid_o, busy_o, done_o;
  logic [7:0]  pair_cnt_o;

  always #5 clk = ~clk;

  seq_pattern_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .pattern_i(pattern_i), .len_i(len_i), .reps_i(reps_i),
    .w_o(w_o), .w_valid_o(w_valid_o), .busy_o(busy_o), .done_o(done_o),
    .pair_cnt_o(pair_cnt_o)
  );

  typedef struct {
    logic       w, v, busy, done;
    logic [7:0] pair;
    bit         first;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pair = 0;
  int   hits = 0;
  bit   prev_one = 0;
  int   done_cyc, vcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected per-cycle outputs of one job, cycle 0 being the start cycle.
  // kind: 0 normal, 1 abort asserted in cycle cut, 2 rst asserted in cycle cut.
  task automatic model_job(input logic [15:0] pat, input int len, input int reps,
                           input int cut, input int kind);
    exp_t seq[$];
    exp_t e;
    int   L, R, pairs;
    bit   prev;
    L = (len > 16) ? 16 : len;
    R = (reps == 0) ? 1 : reps;
    pairs = 0;
    prev = 0;
    e = '{w:0, v:0, busy:0, done:0, pair:8'(model_pair), first:1};
    seq.push_back(e);
    if (L > 0) begin
      for (int r = 0; r < R; r++) begin
        if (r == 0 || GAP > 0) prev = 0;
        for (int i = 0; i < L; i++) begin
          bit b;
          b = pat[L-1-i];
          if (b && prev && pairs < 255) pairs++;
          prev = b;
          e = '{w:b, v:1, busy:1, done:0, pair:8'(pairs), first:0};
          seq.push_back(e);
        end
        if (r < R - 1)
          for (int g = 0; g < GAP; g++) begin
            e = '{w:0, v:0, busy:1, done:0, pair:8'(pairs), first:0};
            seq.push_back(e);
          end
      end
    end
    e = '{w:0, v:0, busy:0, done:1, pair:8'(pairs), first:0};
    seq.push_back(e);
    e = '{w:0, v:0, busy:0, done:0, pair:8'(pairs), first:0};
    seq.push_back(e);
    if (cut >= 0) begin
      while (seq.size() > cut + 1) void'(seq.pop_back());
      pairs = (kind == 1) ? int'(seq[cut].pair) : 0;
      for (int k = 0; k < 2; k++) begin
        e = '{w:0, v:0, busy:0, done:0, pair:8'(pairs), first:0};
        seq.push_back(e);
      end
    end
    model_pair = pairs;
    foreach (seq[k]) exp_q.push_back(seq[k]);
  endtask

  // Per-cycle compare against the model, plus a "11" detector fed by w.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("w", w_o, e.w);
      check("w_valid", w_valid_o, e.v);
      check("busy", busy_o, e.busy);
      check("done", done_o, e.done);
      check("pair_cnt", pair_cnt_o, e.pair);
      if (!e.first) begin
        if (w_valid_o && w_o && prev_one && hits < 255) hits++;
        prev_one = w_valid_o && w_o;
      end
      if (rst) begin
        hits = 0;
        prev_one = 0;
      end else begin
        check("detector_hits", pair_cnt_o, hits);
      end
      if (e.first) begin
        hits = 0;
        prev_one = 0;
      end
    end
  end

  task automatic run_job(input logic [15:0] pat, input int len, input int reps,
                         input int cut, input int kind, input int pulse_cyc);
    int c;
    @(posedge clk); #1;
    model_job(pat, len, reps, cut, kind);
    pattern_i = pat;
    len_i     = 5'(len);
    reps_i    = 4'(reps);
    start_i   = 1'b1;
    done_cyc  = -1;
    vcnt      = 0;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (done_o === 1'b1 && done_cyc < 0) done_cyc = c;
      if (w_valid_o === 1'b1) vcnt++;
      start_i = (c == pulse_cyc);
      if (c == pulse_cyc) begin
        pattern_i = 16'hA5A5;
        len_i     = 5'd8;
      end
      abort_i = (kind == 1 && c == cut);
      rst     = (kind == 2 && c == cut);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    rst     = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expected cycles left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    pattern_i = '0; len_i = '0; reps_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_w", w_o, 0);
    check("reset_w_valid", w_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_pair", pair_cnt_o, 0);
    rst = 1'b0;

    // 1: 0110 once
    run_job(16'h0006, 4, 1, -1, 0, -1);
    check("t1_done_cyc", done_cyc, 5);
    check("t1_pair", pair_cnt_o, 1);
    check("t1_vcnt", vcnt, 4);

    // 2: 111 twice with a two-cycle gap
    run_job(16'h0007, 3, 2, -1, 0, -1);
    check("t2_done_cyc", done_cyc, 9);
    check("t2_pair", pair_cnt_o, 4);
    check("t2_vcnt", vcnt, 6);

    // 3a: empty job
    run_job(16'hFFFF, 0, 3, -1, 0, -1);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_vcnt", vcnt, 0);
    check("t3_pair", pair_cnt_o, 0);

    // 3b: start pulsed mid-stream is ignored
    run_job(16'h0006, 4, 1, -1, 0, 2);
    check("t3b_done_cyc", done_cyc, 5);
    check("t3b_pair", pair_cnt_o, 1);

    // 4: len clamps to 16
    run_job(16'hFFFF, 20, 1, -1, 0, -1);
    check("t4_done_cyc", done_cyc, 17);
    check("t4_pair", pair_cnt_o, 15);
    check("t4_vcnt", vcnt, 16);

    // 5: abort in cycle 2
    run_job(16'h0006, 4, 1, 2, 1, -1);
    check("t5_no_done", done_cyc, -1);
    check("t5_pair", pair_cnt_o, 0);
    check("t5_busy", busy_o, 0);

    // 6: rst in cycle 2, then a clean rerun
    run_job(16'h0007, 3, 2, 2, 2, -1);
    check("t6_no_done", done_cyc, -1);
    check("t6_pair", pair_cnt_o, 0);
    run_job(16'h0007, 3, 2, -1, 0, -1);
    check("t6_rerun_done_cyc", done_cyc, 9);
    check("t6_rerun_pair", pair_cnt_o, 4);

    // reps=0 behaves as one repetition; 1011 x1
    run_job(16'h000B, 4, 0, -1, 0, -1);
    check("t7_done_cyc", done_cyc, 5);
    check("t7_pair", pair_cnt_o, 1);

    // 11011 three times: pairs 2 per rep, history cleared in gaps
    run_job(16'h001B, 5, 3, -1, 0, -1);
    check("t8_done_cyc", done_cyc, 1 + 15 + 4);
    check("t8_pair", pair_cnt_o, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
